// File: rtl/video_timing_pkg.sv
// Shared video timing constants, bar colours and pattern mode encodings.
package video_timing_pkg;

    // Default 640x480 @ 60 Hz timing
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // RGB565 colour bar palette, left to right
    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAY  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_mode_e;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Timing bundle: current counter position plus decoded de/sync/start-of-frame.
interface video_pattern_gen_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;

    modport master (output x, y, de, hs, vs, sof);
    modport slave  (input  x, y, de, hs, vs, sof);
endinterface

// File: rtl/video_timing_cnt.sv
// Reusable h/v raster counter with combinational de/sync decode of the current count.
module video_timing_cnt
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    video_pattern_gen_if.master        tim_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;

    // Next count: disabled parks at (0,0) so a re-enable always starts a fresh frame
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!en_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 11'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Decode of the current count; the consumer registers these
    always_comb begin
        tim_o.x   = h_q;
        tim_o.y   = v_q;
        tim_o.de  = (h_q < H_ACT) && (v_q < V_ACT);
        tim_o.hs  = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        tim_o.vs  = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        tim_o.sof = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Test pattern source: colour bars, gray ramp, checkerboard or solid colour, RGB565.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        video_clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  PAT_MODE,
    input  logic [15:0] SOLID_RGB,
    output logic        rgb565_hs,
    output logic        rgb565_vs,
    output logic        rgb565_de,
    output logic [15:0] rgb565,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    if ((H_ACTIVE % 8) != 0 || H_TOTAL >= 2048 || V_TOTAL >= 1024) begin : g_bad_params
        $error("video_pattern_gen: illegal timing parameters");
    end

    video_pattern_gen_if tim ();

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_cnt (
        .clk_i (video_clk),
        .rst_i (rst),
        .en_i  (en),
        .tim_o (tim.master)
    );

    pat_mode_e   mode_q, mode_d;
    logic [2:0]  bar_idx;
    logic [7:0]  gray;
    logic [15:0] rgb_q, rgb_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

    // Mode latches on the (0,0) clock; mode_d doubles as the mode in force for this pixel
    always_comb begin
        mode_d = mode_q;
        if (en && tim.sof) begin
            mode_d = pat_mode_e'(PAT_MODE);
        end
    end

    // Pattern and output next-state; disabled forces the idle output set
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (tim.x >= 11'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
        gray = tim.x[7:0];

        rgb_d = '0;
        if (tim.de) begin
            case (mode_d)
                PAT_BARS:  rgb_d = bar_colour(bar_idx);
                PAT_GRAY:  rgb_d = {gray[7:3], gray[7:2], gray[7:3]};
                PAT_CHECK: rgb_d = (tim.x[5] ^ tim.y[5]) ? C_WHITE : C_BLACK;
                default:   rgb_d = SOLID_RGB;
            endcase
        end

        x_d  = tim.x;
        y_d  = tim.y;
        de_d = tim.de;
        hs_d = tim.hs;
        vs_d = tim.vs;
        fs_d = tim.sof;
        if (!en) begin
            rgb_d = '0;
            x_d   = '0;
            y_d   = '0;
            de_d  = 1'b0;
            hs_d  = ~SYNC_POL;
            vs_d  = ~SYNC_POL;
            fs_d  = 1'b0;
        end
    end

    // Output and mode registers
    always_ff @(posedge video_clk) begin
        if (rst) begin
            mode_q <= PAT_BARS;
            rgb_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            de_q   <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            fs_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            rgb_q  <= rgb_d;
            x_q    <= x_d;
            y_q    <= y_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
        end
    end

    assign rgb565      = rgb_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign rgb565_de   = de_q;
    assign rgb565_hs   = hs_q;
    assign rgb565_vs   = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench: 640-wide raster with a short vertical, plus a tiny positive-sync instance.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        en_s = 1'b0;
    logic [1:0]  pat_mode = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic [15:0] rgb;

    logic        s_hs, s_vs, s_de, s_fs;
    logic [15:0] s_rgb;
    logic [10:0] s_x;
    logic [9:0]  s_y;

    int n_chk = 0;
    int n_pass = 0;

    video_pattern_gen_if vid ();

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
        .V_ACTIVE (34),  .V_FP (1),  .V_SYNC (2),  .V_BP (1),
        .SYNC_POL (1'b0)
    ) dut (
        .video_clk   (clk),
        .rst         (rst),
        .en          (en),
        .PAT_MODE    (pat_mode),
        .SOLID_RGB   (solid_rgb),
        .rgb565_hs   (vid.hs),
        .rgb565_vs   (vid.vs),
        .rgb565_de   (vid.de),
        .rgb565      (rgb),
        .pix_x       (vid.x),
        .pix_y       (vid.y),
        .frame_start (vid.sof)
    );

    video_pattern_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1)
    ) dut_s (
        .video_clk   (clk),
        .rst         (rst),
        .en          (en_s),
        .PAT_MODE    (2'd0),
        .SOLID_RGB   (16'h0000),
        .rgb565_hs   (s_hs),
        .rgb565_vs   (s_vs),
        .rgb565_de   (s_de),
        .rgb565      (s_rgb),
        .pix_x       (s_x),
        .pix_y       (s_y),
        .frame_start (s_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_pix(input int x, input int y);
        int  n;
        bit  found;
        n = 0;
        found = 0;
        while (!found && n < 40000) begin
            @(negedge clk);
            n++;
            if (int'(vid.x) == x && int'(vid.y) == y) found = 1;
        end
        check($sformatf("reach_%0d_%0d", x, y), 32'(found), 32'd1);
    endtask

    task automatic wait_fs();
        int  n;
        bit  found;
        n = 0;
        found = 0;
        while (!found && n < 40000) begin
            @(negedge clk);
            n++;
            if (vid.sof) found = 1;
        end
        check("reach_frame_start", 32'(found), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_de"}, 32'(vid.de), 32'd0);
        check({tag, "_hs"}, 32'(vid.hs), 32'd1);
        check({tag, "_vs"}, 32'(vid.vs), 32'd1);
        check({tag, "_rgb"}, 32'(rgb), 32'h0);
        check({tag, "_x"}, 32'(vid.x), 32'd0);
        check({tag, "_y"}, 32'(vid.y), 32'd0);
        check({tag, "_fs"}, 32'(vid.sof), 32'd0);
    endtask

    // Raster monitor over the first two frames after b_on
    int   cyc = 0;
    bit   b_on = 0;
    int   b_fs_n = 0, b_last = 0, b_per1 = 0, b_per2 = 0;
    int   de_run = 0, de_runs = 0, de_bad = 0;
    int   hs_run = 0, hs_runs = 0, hs_bad = 0;
    int   vs_clks = 0, vs_bad = 0;
    logic de_p = 1'b0, hs_p = 1'b1, vs_p = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (b_on) begin
            if (vid.sof) begin
                b_fs_n++;
                if (b_fs_n == 2) b_per1 = cyc - b_last;
                if (b_fs_n == 3) b_per2 = cyc - b_last;
                b_last = cyc;
            end
            if (b_fs_n == 1 || b_fs_n == 2) begin
                if (vid.de) de_run++;
                else if (de_p) begin
                    de_runs++;
                    if (de_run != 640) de_bad++;
                    de_run = 0;
                end
                if (!vid.hs) begin
                    if (hs_p && vid.x != 11'd656) hs_bad++;
                    hs_run++;
                end else if (!hs_p) begin
                    hs_runs++;
                    if (hs_run != 96) hs_bad++;
                    hs_run = 0;
                end
                if (!vid.vs) begin
                    vs_clks++;
                    if (vs_p && vid.y != 10'd35) vs_bad++;
                end
            end
            de_p = vid.de;
            hs_p = vid.hs;
            vs_p = vid.vs;
        end
    end

    // Small-timing monitor over its first frame
    int   s_fs_n = 0, s_last = 0, s_period = 0;
    int   s_hs_hi = 0, s_hs_runs = 0, s_vs_hi = 0, s_de_hi = 0;
    logic s_hs_p = 1'b0;

    always @(negedge clk) begin
        if (s_fs) begin
            s_fs_n++;
            if (s_fs_n == 2) s_period = cyc - s_last;
            s_last = cyc;
        end
        if (s_fs_n == 1) begin
            if (s_hs) s_hs_hi++;
            if (s_hs && !s_hs_p) s_hs_runs++;
            if (s_vs) s_vs_hi++;
            if (s_de) s_de_hi++;
        end
        s_hs_p = s_hs;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("s_reset_hs", 32'(s_hs), 32'd0);
        check("s_reset_vs", 32'(s_vs), 32'd0);

        // Frame 1: checkerboard
        pat_mode = 2'd2;
        rst  = 1'b0;
        en   = 1'b1;
        en_s = 1'b1;
        b_on = 1'b1;
        @(negedge clk);
        check("f1_fs", 32'(vid.sof), 32'd1);
        check("f1_x0", 32'(vid.x), 32'd0);
        check("f1_de0", 32'(vid.de), 32'd1);
        check("f1_rgb00", 32'(rgb), 32'h0000);
        wait_pix(32, 0);
        check("chk_32_0", 32'(rgb), 32'hFFFF);
        wait_pix(0, 32);
        check("chk_0_32", 32'(rgb), 32'hFFFF);
        wait_pix(32, 32);
        check("chk_32_32", 32'(rgb), 32'h0000);
        wait_pix(0, 33);
        pat_mode = 2'd0;
        wait_pix(80, 33);
        check("midframe_mode_ignored", 32'(rgb), 32'hFFFF);

        // Frame 2: bars, mode change mid-frame
        wait_fs();
        check("bars_0", 32'(rgb), 32'hFFFF);
        wait_pix(79, 0);
        check("bars_79", 32'(rgb), 32'hFFFF);
        wait_pix(80, 0);
        check("bars_80", 32'(rgb), 32'hFFE0);
        wait_pix(160, 0);
        check("bars_160", 32'(rgb), 32'h07FF);
        wait_pix(480, 0);
        check("bars_480", 32'(rgb), 32'h001F);
        wait_pix(639, 0);
        check("bars_639", 32'(rgb), 32'h0000);
        check("de_639", 32'(vid.de), 32'd1);
        wait_pix(640, 0);
        check("rgb_640", 32'(rgb), 32'h0000);
        check("de_640", 32'(vid.de), 32'd0);
        wait_pix(0, 20);
        pat_mode  = 2'd3;
        solid_rgb = 16'hF800;
        wait_pix(80, 25);
        check("still_bars", 32'(rgb), 32'hFFE0);

        // Frame 3: solid colour
        wait_fs();
        check("solid_00", 32'(rgb), 32'hF800);
        wait_pix(639, 1);
        check("solid_639", 32'(rgb), 32'hF800);
        wait_pix(640, 1);
        check("solid_640", 32'(rgb), 32'h0000);

        // Reset mid-frame
        wait_pix(299, 2);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check("rst_fs", 32'(vid.sof), 32'd1);
        check("rst_x", 32'(vid.x), 32'd0);
        check("rst_y", 32'(vid.y), 32'd0);
        check("rst_rgb", 32'(rgb), 32'hF800);

        // en dropped mid-line, restart in gray mode
        wait_pix(100, 0);
        en = 1'b0;
        @(negedge clk);
        check_idle("en_drop");
        en = 1'b1;
        pat_mode = 2'd1;
        @(negedge clk);
        check("en_fs", 32'(vid.sof), 32'd1);
        check("en_x", 32'(vid.x), 32'd0);
        check("gray_0", 32'(rgb), 32'h0000);
        wait_pix(128, 0);
        check("gray_128", 32'(rgb), 32'h8410);
        wait_pix(255, 0);
        check("gray_255", 32'(rgb), 32'hFFFF);
        wait_pix(256, 0);
        check("gray_256", 32'(rgb), 32'h0000);

        // Raster statistics
        check("period1", 32'(b_per1), 32'd30400);
        check("period2", 32'(b_per2), 32'd30400);
        check("de_lines", 32'(de_runs), 32'd68);
        check("de_len_bad", 32'(de_bad), 32'd0);
        check("hs_pulses", 32'(hs_runs), 32'd76);
        check("hs_bad", 32'(hs_bad), 32'd0);
        check("vs_clocks", 32'(vs_clks), 32'd3200);
        check("vs_start_bad", 32'(vs_bad), 32'd0);

        check("s_period", 32'(s_period), 32'd98);
        check("s_hs_hi", 32'(s_hs_hi), 32'd14);
        check("s_hs_pulses", 32'(s_hs_runs), 32'd7);
        check("s_vs_hi", 32'(s_vs_hi), 32'd14);
        check("s_de_hi", 32'(s_de_hi), 32'd32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, active lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, level of hs/vs during their sync pulse (0 = active-low).
REQ-002 SHALL have ports (name, direction, width, meaning):
- video_clk, in, 1: only clock.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: run enable.
- PAT_MODE, in, 2: 0 colour bars, 1 gray ramp, 2 checkerboard, 3 solid colour.
- SOLID_RGB, in, 16: RGB565 value for mode 3.
- rgb565_hs, rgb565_vs, rgb565_de, out, 1 each: video timing feeding the edge pipeline.
- rgb565, out, 16: pixel, RGB565 (R[15:11] G[10:5] B[4:0]).
- pix_x, out, 11: horizontal counter of the pixel currently on the outputs.
- pix_y, out, 10: vertical counter of the pixel currently on the outputs.
- frame_start, out, 1: one-cycle pulse on pixel (0,0).

Function
REQ-003 SHALL keep an internal h counter from 0 to H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
REQ-004 SHALL keep an internal v counter from 0 to V_TOTAL-1, where V_TOTAL is the equivalent vertical sum (525 by default).
REQ-005 The v counter SHALL increment only when h wraps to 0; v SHALL wrap to 0 when it reaches V_TOTAL-1 and h wraps.
REQ-006 Counters SHALL advance one step per clock while en=1; all outputs SHALL be registered.
REQ-007 Outputs SHALL describe the counter state of the previous clock (1-cycle latency); pixel (0,0) SHALL appear on the outputs the cycle after en is first sampled high.
REQ-008 rgb565_de SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-009 rgb565_hs SHALL be at SYNC_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL be at !SYNC_POL.
REQ-010 rgb565_vs SHALL be at SYNC_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line regardless of h; otherwise it SHALL be at !SYNC_POL.
REQ-011 rgb565 SHALL be 16'h0000 whenever de=0.
REQ-012 Mode 0 SHALL output 8 equal bars of width H_ACTIVE/8, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-013 Mode 1 SHALL use g=pix_x[7:0] and output {g[7:3],g[7:2],g[7:3]}.
REQ-014 Mode 2 SHALL output FFFF when x[5]^y[5]=1, else 0000 (32x32 squares).
REQ-015 Mode 3 SHALL output SOLID_RGB as sampled on the same clock as the pixel.
REQ-016 The effective pattern mode SHALL be latched only on the clock processing counter (0,0); pixel (0,0) SHALL already use the newly sampled PAT_MODE; mid-frame PAT_MODE changes SHALL have no effect until the next frame.
REQ-017 frame_start SHALL be 1 exactly on the output cycle of pixel (0,0), and 0 otherwise.
REQ-018 en=0 SHALL reset both counters to (0,0) on the next clock and drive idle outputs: de=0, hs=vs=!SYNC_POL, rgb565=0, pix_x=pix_y=0, frame_start=0.
REQ-019 Re-asserting en SHALL restart at frame start; no partial frame SHALL resume.
REQ-020 Parameter legality (H_ACTIVE divisible by 8, H_TOTAL<2048, V_TOTAL<1024) SHALL be checked at elaboration only; no runtime checking.

Reset
REQ-021 rst=1 SHALL, on the next video_clk edge, clear counters and the latched mode to 0 and force the idle outputs of REQ-018; this has priority over en.
REQ-022 Reset asserted mid-frame SHALL abort the frame; the first pixel after release (with en=1) SHALL be (0,0) with frame_start=1.

Structure
REQ-023 A shared package video_timing_pkg SHALL hold the default 640x480 timing constants, the eight RGB565 bar colour constants and the PAT_MODE encodings.
REQ-024 The h/v counters, de and sync generation SHALL live in a sub-module video_timing_cnt, reusable by other video sources; pattern logic and output registers SHALL stay in the top module.

Verification
REQ-025 Defaults, en=1 for 2 frames: exactly 800*525 = 420000 clocks between frame_start pulses, 640 de-high clocks per active line, 480 active lines, hs low for 96 clocks starting at pix_x=656, vs low for lines 490-491.
REQ-026 PAT_MODE=0: line 0 pixels 0, 79, 80, 639 = FFFF, FFFF, FFE0, 0000; pix_x=640 gives rgb565=0.
REQ-027 PAT_MODE=1 then 2: pixel x=255 gives FFFF; x=256 gives 0000. Under mode 2, (x,y)=(32,0) gives FFFF and (32,32) gives 0000.
REQ-028 PAT_MODE changed 0->3 with SOLID_RGB=F800 at line 100: the rest of the frame stays bars; the next frame is all F800 in active area.
REQ-029 rst pulsed at (h,v)=(300,200), then en=1: the outputs after reset are idle for one cycle, then pixel (0,0) with frame_start=1; same check for en dropped mid-line.
REQ-030 SYNC_POL=1, small timing (H 8/2/2/2, V 4/1/1/1): hs high exactly 2 clocks per 14-clock line, vs high for 1 line per 7-line frame.
